// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between imem0/imem1/dmem0/dmem1
module mem_port_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [3:0]             req_valid,
    input  logic [4*XLEN-1:0]      req_addr,
    input  logic [4*XLEN-1:0]      req_wdata,
    input  logic [4*(XLEN/8)-1:0]  req_wstrb,
    output logic [3:0]             req_ready,
    output logic [3:0]             req_error,
    output logic [XLEN-1:0]        req_rdata,
    output logic                   mem_valid,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_wdata,
    output logic [XLEN/8-1:0]      mem_wstrb,
    input  logic                   mem_ready,
    input  logic [XLEN-1:0]        mem_rdata,
    input  logic                   mem_error
);
    localparam int SW = XLEN / 8;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_next;

    logic [3:0]      pend, accept, avail;
    logic [XLEN-1:0] addr_q [4];
    logic [XLEN-1:0] wdata_q [4];
    logic [SW-1:0]   wstrb_q [4];
    logic [1:0]      gnt, last_gnt, pick;
    logic            found, grant, expire, done;
    logic [CW-1:0]   cnt;

    // clear masks the instruction requesters both for new pulses and for arbitration
    assign accept = req_valid & ~{2'b00, clear, clear};
    assign avail  = pend & ~{2'b00, clear, clear};
    assign grant  = state == IDLE && found;
    assign expire = (TIMEOUT != 0) && state == WAIT && !mem_ready && cnt == LAST;
    assign done   = state == WAIT && (mem_ready || expire);

    // round-robin search starting one past the previous winner
    always_comb begin
        pick  = last_gnt;
        found = 1'b0;
        for (int k = 1; k < 5; k++) begin
            if (!found && avail[last_gnt + 2'(k)]) begin
                pick  = last_gnt + 2'(k);
                found = 1'b1;
            end
        end
    end

    // next state: grant moves to WAIT, response or watchdog returns to IDLE
    always_comb begin
        state_next = state;
        if (grant)
            state_next = WAIT;
        else if (done)
            state_next = IDLE;
    end

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // per-requester pending latch, newest pulse overwrites stored fields
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend <= '0;
            for (int i = 0; i < 4; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                wstrb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept[i]) begin
                    pend[i]    <= 1'b1;
                    addr_q[i]  <= req_addr[i*XLEN +: XLEN];
                    wdata_q[i] <= req_wdata[i*XLEN +: XLEN];
                    wstrb_q[i] <= req_wstrb[i*SW +: SW];
                end else if ((i < 2 && clear) || (grant && pick == 2'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // memory-side request registers, watchdog and registered responses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            req_ready <= '0;
            req_error <= '0;
            req_rdata <= '0;
            gnt       <= '0;
            last_gnt  <= 2'd3;
            cnt       <= '0;
        end else begin
            mem_valid <= grant;
            req_ready <= '0;
            req_error <= '0;
            req_rdata <= '0;
            if (grant) begin
                mem_addr  <= addr_q[pick];
                mem_wdata <= wdata_q[pick];
                mem_wstrb <= wstrb_q[pick];
                gnt       <= pick;
                last_gnt  <= pick;
                cnt       <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (done) begin
                req_ready[gnt] <= 1'b1;
                req_error[gnt] <= expire || mem_error;
                req_rdata      <= expire ? '0 : mem_rdata;
            end
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one backing memory port between the four CPU memory requesters: instruction ports 0/1 and data ports 0/1. Sits between the core's `imem0/imem1/dmem0/dmem1` ports and a single-ported memory or bus bridge. Behaviour:
- Latches single-cycle requests.
- Arbitrates round-robin and keeps one transaction outstanding.
- Routes each response back to its originator.
- Aborts with an error if the memory does not answer within a bounded time.

## Interface
Parameters:
- `XLEN`, 32, address/data width.
- `TIMEOUT`, 255, cycles to wait for `mem_ready` before erroring; 0 disables the watchdog.

Ports (requester index: 0=imem0, 1=imem1, 2=dmem0, 3=dmem1):
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous pipeline flush; drops pending instruction requests.
- `req_valid`  in  4  one-cycle request pulse per requester.
- `req_addr`  in  4*XLEN  request address; slice i belongs to requester i.
- `req_wdata`  in  4*XLEN  write data.
- `req_wstrb`  in  4*(XLEN/8)  byte strobes; all-zero means read.
- `req_ready`  out  4  one-cycle response pulse to requester i.
- `req_error`  out  4  error flag, valid with `req_ready`.
- `req_rdata`  out  XLEN  shared read data, qualified by `req_ready`.
- `mem_valid`  out  1  one-cycle request to memory.
- `mem_addr`  out  XLEN  memory address.
- `mem_wdata`  out  XLEN  memory write data.
- `mem_wstrb`  out  XLEN/8  memory byte strobes.
- `mem_ready`  in  1  memory completion pulse.
- `mem_rdata`  in  XLEN  memory read data.
- `mem_error`  in  1  memory access fault.

## Operation
- **Pending latch, per requester:** `pend[i]`, `addr`, `wdata`, `wstrb`.
  - `req_valid[i]` sets `pend[i]` and overwrites the stored fields, including when `pend[i]` is already 1 (newest wins).
- **States:**
  - `IDLE`: if any `pend` is set, grant one requester. Copy its fields into the `mem_*` registers, record `gnt`, clear `pend[gnt]` (unless `req_valid[gnt]` is high in the same cycle, in which case it re-latches), then go to `WAIT`.
  - `WAIT`: first cycle drives `mem_valid`=1. On `mem_ready`: pulse `req_ready[gnt]`, pass `req_error[gnt]`=`mem_error`, pass `req_rdata`=`mem_rdata`, then go to `IDLE`. On watchdog expiry: `req_ready[gnt]`=1, `req_error[gnt]`=1, `req_rdata`=0, then go to `IDLE`.
- **Round-robin:** search starts at `(last_gnt+1) mod 4`; `last_gnt` updates at each grant.
- **Watchdog:** counter starts at 0 on entry to `WAIT` and increments each `WAIT` cycle without `mem_ready`. Expiry occurs when count == `TIMEOUT`-1 with no `mem_ready`. `mem_ready` in the expiry cycle wins (normal response).
- **`clear`:**
  - Clears `pend[0]` and `pend[1]`, and suppresses `req_valid[1:0]` latching in the same cycle.
  - Does not affect data pends or the in-flight transaction. An in-flight instruction response is still delivered.
- **`mem_ready` outside `WAIT`:** ignored.

## Timing
- **Reset values:** all outputs 0, state `IDLE`, `pend`=0, `last_gnt`=3 (so imem0 wins first), counter 0.
- **All outputs are registered.**
- **Zero-wait memory:**
  - `req_valid` in cycle N.
  - Grant in N+1.
  - `mem_valid` in N+2 (`mem_ready` accepted from N+2).
  - `req_ready` in N+3.
- **Response latency:** `req_ready` follows `mem_ready` by exactly 1 cycle.
- **Throughput:** one transaction per 2 cycles minimum (`WAIT`→`IDLE`→`WAIT`).
- **`mem_valid`** is high for exactly one cycle per transaction. `mem_addr`/`wdata`/`wstrb` hold stable through `WAIT`.
- **`req_ready`** is one-hot or zero and high for exactly one cycle. `req_rdata` and `req_error` are 0 when `req_ready`=0.
- **Reset mid-transaction:** all state is discarded and no response is issued.

## Test plan
- **Single read:** reset, then `req_valid`=0100 with `addr[2]`=0x1000, `wstrb`=0. Memory answers `mem_ready` in the same cycle as `mem_valid` with rdata 0xDEADBEEF. Required: `mem_addr`=0x1000 in N+2; `req_ready`=0100, `req_rdata`=0xDEADBEEF in N+3.
- **All four requesters pulse in the same cycle, zero-wait memory:** grant order 0,1,2,3. `req_ready` pulses at N+3, N+5, N+7, N+9.
- **Overwrite and collision:**
  - imem1 pulses addr 0x20 then 0x40 before its grant. Required: single `mem_valid` with 0x40.
  - Requester re-pulses in its own grant cycle. Required: second transaction follows.
- **`clear`:** pend imem0, imem1 and dmem1, assert `clear` while `IDLE`. Required: only dmem1 is issued and answered.
- **Timeout:** `TIMEOUT`=4, memory never answers. Required: `req_ready`+`req_error` on the granted requester 1 cycle after the 4th `WAIT` cycle, `req_rdata`=0, next pend then issued. Variant: `mem_ready` in the 4th cycle gives a normal response.
- **Async reset:** assert `reset` low during `WAIT`. Required: immediate return to `IDLE`, outputs 0, no `req_ready`; first grant after release is imem0.
